// File: rtl/wt_store_coalesce_buf.sv
// Write-through store coalescing buffer: word stores merge into line-sized entries,
// which drain in allocation order once aged out, fully written, flushed, or the buffer fills.

module wt_store_coalesce_entry #(
    parameter int LA_W   = 28,
    parameter int LINE_W = 128,
    parameter int AGE_W  = 3,
    parameter int TH     = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                alloc,
    input  logic                merge,
    input  logic                free,
    input  logic [LA_W-1:0]     wr_line,
    input  logic [LINE_W-1:0]   wr_data,
    input  logic [LINE_W/8-1:0] wr_be,
    output logic                valid,
    output logic [LA_W-1:0]     line,
    output logic [LINE_W-1:0]   data,
    output logic [LINE_W/8-1:0] be,
    output logic                age_sat
);
    logic [AGE_W-1:0] age;

    assign age_sat = (age == AGE_W'(TH));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid <= 1'b0;
            line  <= '0;
            data  <= '0;
            be    <= '0;
            age   <= '0;
        end else if (alloc) begin
            valid <= 1'b1;
            line  <= wr_line;
            be    <= wr_be;
            age   <= '0;
            for (int b = 0; b < LINE_W/8; b++)
                data[b*8 +: 8] <= wr_be[b] ? wr_data[b*8 +: 8] : 8'h00;
        end else if (merge) begin
            be  <= be | wr_be;
            age <= '0;
            for (int b = 0; b < LINE_W/8; b++)
                if (wr_be[b]) data[b*8 +: 8] <= wr_data[b*8 +: 8];
        end else if (free) begin
            valid <= 1'b0;
            age   <= '0;
        end else if (valid && !age_sat) begin
            age <= age + AGE_W'(1);
        end
    end
endmodule

module wt_store_coalesce_buf #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_W = 128,
    parameter int TH     = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [ADDR_W-1:0]   in_addr_i,
    input  logic [DATA_W-1:0]   in_data_i,
    input  logic [DATA_W/8-1:0] in_be_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [ADDR_W-1:0]   out_addr_o,
    output logic [LINE_W-1:0]   out_data_o,
    output logic [LINE_W/8-1:0] out_be_o,
    input  logic                flush_i,
    output logic                empty_o,
    input  logic [ADDR_W-1:0]   chk_addr_i,
    output logic                chk_hit_o
);
    localparam int BE_W   = DATA_W / 8;
    localparam int LBE_W  = LINE_W / 8;
    localparam int LANES  = LINE_W / DATA_W;
    localparam int OFF_W  = $clog2(LBE_W);
    localparam int WOFF_W = $clog2(BE_W);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int LA_W   = ADDR_W - OFF_W;
    localparam int AGE_W  = (TH > 0) ? $clog2(TH + 1) : 1;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } st_req_t;

    st_req_t           req;
    logic [LA_W-1:0]   req_line;
    logic [LANE_W-1:0] req_lane;
    logic [LINE_W-1:0] wr_data;
    logic [LBE_W-1:0]  wr_be;

    assign req      = '{addr: in_addr_i, data: in_data_i, be: in_be_i};
    assign req_line = LA_W'(req.addr >> OFF_W);
    assign req_lane = LANE_W'(req.addr[OFF_W-1:0] >> WOFF_W);
    assign wr_data  = {LANES{req.data}};
    assign wr_be    = LBE_W'(req.be) << {req_lane, {WOFF_W{1'b0}}};

    logic [DEPTH-1:0]             e_valid, e_sat;
    logic [DEPTH-1:0][LA_W-1:0]   e_line;
    logic [DEPTH-1:0][LINE_W-1:0] e_data;
    logic [DEPTH-1:0][LBE_W-1:0]  e_be;

    // ord[0] is always the oldest valid entry; cnt entries of ord are live
    logic [DEPTH-1:0][IDX_W-1:0]  ord, ord_n;
    logic [CNT_W-1:0]             cnt, cnt_n;
    logic [IDX_W-1:0]             head, m_idx, a_idx;
    logic                         flush_pend, head_elig, m_hit, a_ok, accept, fire;

    assign head      = ord[0];
    assign head_elig = e_valid[head] &&
                       (e_sat[head] || (&e_be[head]) || flush_pend || (&e_valid));
    assign fire      = head_elig && out_ready_i;
    assign accept    = in_valid_i && in_ready_o;

    assign out_valid_o = head_elig;
    assign out_addr_o  = {e_line[head], {OFF_W{1'b0}}};
    assign out_data_o  = e_data[head];
    assign out_be_o    = e_be[head];
    assign empty_o     = ~|e_valid;
    assign in_ready_o  = !flush_pend && (m_hit || a_ok);

    // A head that is already presenting is frozen, so it is never a merge target
    always_comb begin
        m_hit     = 1'b0;
        m_idx     = '0;
        a_ok      = 1'b0;
        a_idx     = '0;
        chk_hit_o = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (e_valid[i] && e_line[i] == req_line && !(head_elig && head == IDX_W'(i))) begin
                m_hit = 1'b1;
                m_idx = IDX_W'(i);
            end
            if (!e_valid[i]) begin
                a_ok  = 1'b1;
                a_idx = IDX_W'(i);
            end
            if (e_valid[i] && ADDR_W'(e_line[i]) == (chk_addr_i >> OFF_W))
                chk_hit_o = 1'b1;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        wt_store_coalesce_entry #(
            .LA_W(LA_W), .LINE_W(LINE_W), .AGE_W(AGE_W), .TH(TH)
        ) u_ent (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .alloc   (accept && !m_hit && a_idx == IDX_W'(i)),
            .merge   (accept && m_hit && m_idx == IDX_W'(i)),
            .free    (fire && head == IDX_W'(i)),
            .wr_line (req_line),
            .wr_data (wr_data),
            .wr_be   (wr_be),
            .valid   (e_valid[i]),
            .line    (e_line[i]),
            .data    (e_data[i]),
            .be      (e_be[i]),
            .age_sat (e_sat[i])
        );
    end

    always_comb begin
        ord_n = ord;
        cnt_n = cnt;
        if (fire) begin
            for (int k = 0; k < DEPTH - 1; k++) ord_n[k] = ord[k+1];
            cnt_n = cnt - CNT_W'(1);
        end
        if (accept && !m_hit) begin
            for (int k = 0; k < DEPTH; k++)
                if (CNT_W'(k) == cnt_n) ord_n[k] = a_idx;
            cnt_n = cnt_n + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ord        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else begin
            ord        <= ord_n;
            cnt        <= cnt_n;
            flush_pend <= (flush_pend || (flush_i && !empty_o)) && (cnt_n != '0);
        end
    end
endmodule

// File: tb/tb_wt_store_coalesce_buf.sv
// Bench for wt_store_coalesce_buf: directed scenarios plus random traffic checked
// against a queue-based model of the buffer kept in allocation order.

module tb_wt_store_coalesce_buf;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LINE_W = 128;
    localparam int TH     = 4;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready, flush, empty, chk_hit;
    logic [31:0]  in_addr, in_data, out_addr, chk_addr;
    logic [3:0]   in_be;
    logic [127:0] out_data;
    logic [15:0]  out_be;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    wt_store_coalesce_buf #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W), .TH(TH)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_addr_i(in_addr), .in_data_i(in_data), .in_be_i(in_be),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_addr_o(out_addr), .out_data_o(out_data), .out_be_o(out_be),
        .flush_i(flush), .empty_o(empty),
        .chk_addr_i(chk_addr), .chk_hit_o(chk_hit)
    );

    // Model: one element per live line, front = oldest allocation
    typedef struct {
        logic [27:0]  line;
        logic [127:0] data;
        logic [15:0]  be;
        int           age;
    } ment_t;

    ment_t mq[$];
    bit    m_fpend;

    function automatic void m_reset();
        mq.delete();
        m_fpend = 1'b0;
    endfunction

    function automatic bit m_elig();
        if (mq.size() == 0) return 1'b0;
        return (mq[0].age >= TH) || (mq[0].be == 16'hFFFF) || m_fpend || (mq.size() == DEPTH);
    endfunction

    function automatic int m_merge_idx(input logic [31:0] a);
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].line == a[31:4] && !(i == 0 && m_elig())) return i;
        return -1;
    endfunction

    function automatic bit m_ready(input logic [31:0] a);
        return !m_fpend && (m_merge_idx(a) >= 0 || mq.size() < DEPTH);
    endfunction

    function automatic bit m_chk(input logic [31:0] a);
        foreach (mq[i]) if (mq[i].line == a[31:4]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic ment_t m_put(input ment_t e, input logic [31:0] a, input logic [31:0] d,
                                    input logic [3:0] b);
        ment_t r;
        int    lane;
        r    = e;
        lane = int'(a[3:2]);
        for (int k = 0; k < 4; k++)
            if (b[k]) begin
                r.data[(lane*4+k)*8 +: 8] = d[k*8 +: 8];
                r.be[lane*4+k]            = 1'b1;
            end
        r.age = 0;
        return r;
    endfunction

    function automatic void m_step(input bit v, input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] b, input bit ordy, input bit fl);
        bit    acc, go, was_empty;
        int    mi;
        ment_t ne;
        acc       = v && m_ready(a);
        mi        = m_merge_idx(a);
        go        = m_elig() && ordy;
        was_empty = (mq.size() == 0);
        foreach (mq[i]) if (mq[i].age < TH) mq[i].age = mq[i].age + 1;
        if (acc && mi >= 0) mq[mi] = m_put(mq[mi], a, d, b);
        if (go) void'(mq.pop_front());
        if (acc && mi < 0) begin
            ne.line = a[31:4];
            ne.data = '0;
            ne.be   = '0;
            ne.age  = 0;
            mq.push_back(m_put(ne, a, d, b));
        end
        if (fl && !was_empty) m_fpend = 1'b1;
        if (mq.size() == 0) m_fpend = 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        in_be    = b;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b0; flush = 1'b0; chk_addr = 32'h8000_0000;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        checks++; if (in_ready !== 1'b1)  $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        checks++; if (empty !== 1'b1)     $display("FAIL reset_empty got=%b exp=1", empty);
        checks++; if (chk_hit !== 1'b0)   $display("FAIL reset_chk_hit got=%b exp=0", chk_hit);
        errors += (out_valid !== 1'b0) + (in_ready !== 1'b1) + (empty !== 1'b1) + (chk_hit !== 1'b0);
        m_reset();
    endtask

    task automatic test_merge();
        out_ready = 1'b0;
        drive(1'b1, 32'h8000_0000, 32'h1111_1111, 4'hF);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL merge_rdy0 got=%b exp=1", in_ready); end
        tick();
        drive(1'b1, 32'h8000_0004, 32'h0000_2222, 4'h3);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL merge_rdy1 got=%b exp=1", in_ready); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL merge_early k=%0d got=%b exp=0", k, out_valid); end
            tick();
        end
        chk_addr = 32'h8000_0008;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL merge_valid got=%b exp=1", out_valid); end
        checks++; if (out_addr !== 32'h8000_0000) begin errors++; $display("FAIL merge_addr got=%h exp=80000000", out_addr); end
        checks++; if (out_be !== 16'h003F) begin errors++; $display("FAIL merge_be got=%h exp=003f", out_be); end
        checks++;
        if (out_data[47:0] !== 48'h2222_1111_1111) begin
            errors++; $display("FAIL merge_data got=%h exp=222211111111", out_data[47:0]);
        end
        checks++; if (chk_hit !== 1'b1) begin errors++; $display("FAIL merge_chk got=%b exp=1", chk_hit); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL merge_empty got=%b exp=1", empty); end
    endtask

    task automatic test_full_line();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h8000_0010 + 32'(k*4), 32'hA0A0_0000 + 32'(k), 4'hF);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL line_early k=%0d got=%b exp=0", k, out_valid); end
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL line_valid got=%b exp=1", out_valid); end
        checks++; if (out_be !== 16'hFFFF) begin errors++; $display("FAIL line_be got=%h exp=ffff", out_be); end
        checks++; if (out_addr !== 32'h8000_0010) begin errors++; $display("FAIL line_addr got=%h exp=80000010", out_addr); end
        checks++;
        if (out_data !== 128'hA0A0_0003_A0A0_0002_A0A0_0001_A0A0_0000) begin
            errors++; $display("FAIL line_data got=%h", out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL line_empty got=%b exp=1", empty); end
    endtask

    task automatic test_full_buffer();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h8000_0000 + 32'((k+1) * 256), 32'hB0 + 32'(k), 4'hF);
            tick();
        end
        drive(1'b1, 32'h8000_0500, 32'hDEAD_BEEF, 4'hF);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid got=%b exp=1", out_valid); end
        checks++; if (out_addr !== 32'h8000_0100) begin errors++; $display("FAIL full_head got=%h exp=80000100", out_addr); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_new_line got=%b exp=0", in_ready); end
        drive(1'b1, 32'h8000_0204, 32'hCCCC_CCCC, 4'hF);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_merge_rdy got=%b exp=1", in_ready); end
        tick();
        drive(1'b1, 32'h8000_0108, 32'h5555_5555, 4'hF);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_head_rdy got=%b exp=0", in_ready); end
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int w;
            w = 0;
            while (out_valid !== 1'b1 && w < 10) begin tick(); #1; w++; end
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL full_drain_timeout k=%0d got=%b exp=1", k, out_valid); end
            checks++;
            if (out_addr !== 32'h8000_0000 + 32'((k+1) * 256)) begin
                errors++; $display("FAIL full_drain_addr k=%0d got=%h exp=%h", k, out_addr, 32'h8000_0000 + 32'((k+1) * 256));
            end
            if (k == 1) begin
                checks++;
                if (out_be !== 16'h00FF) begin errors++; $display("FAIL full_merged_be got=%h exp=00ff", out_be); end
            end
            tick();
            #1;
        end
        out_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_empty got=%b exp=1", empty); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h8000_1000 * 32'(k+1), 32'h1000 + 32'(k), 4'hF);
            tick();
        end
        drive(1'b0, 32'h8000_9000, 32'h0, 4'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_valid k=%0d got=%b exp=1", k, out_valid); end
            checks++;
            if (out_addr !== 32'h8000_1000 * 32'(k+1)) begin
                errors++; $display("FAIL flush_addr k=%0d got=%h exp=%h", k, out_addr, 32'h8000_1000 * 32'(k+1));
            end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_rdy k=%0d got=%b exp=0", k, in_ready); end
            tick();
        end
        out_ready = 1'b0;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got=%b exp=1", empty); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_rdy_after got=%b exp=1", in_ready); end
    endtask

    task automatic test_reset_mid_drain();
        int w;
        out_ready = 1'b0;
        drive(1'b1, 32'h8000_4000, 32'h1234_5678, 4'hF);
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        chk_addr = 32'h8000_4004;
        #1;
        w = 0;
        while (out_valid !== 1'b1 && w < 10) begin tick(); #1; w++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_wait got=%b exp=1", out_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got=%b exp=1", empty); end
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL rstmid_chk got=%b exp=0", chk_hit); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_rdy got=%b exp=1", in_ready); end
        m_reset();
    endtask

    task automatic test_random();
        logic         v, ordy, fl;
        logic [31:0]  a, d;
        logic [3:0]   b;
        logic [127:0] m, ed;
        logic [15:0]  eb;
        for (int c = 0; c < 1500; c++) begin
            v    = ($urandom_range(0, 99) < 70);
            ordy = ($urandom_range(0, 99) < 50);
            fl   = ($urandom_range(0, 99) < 4);
            a    = 32'h8000_0000 | (32'($urandom_range(0, 5)) << 4) | 32'($urandom_range(0, 15));
            d    = $urandom;
            b    = 4'($urandom_range(0, 15));
            drive(v, a, d, b);
            out_ready = ordy;
            flush     = fl;
            chk_addr  = 32'h8000_0000 | (32'($urandom_range(0, 6)) << 4) | 32'($urandom_range(0, 15));
            #1;
            checks++;
            if (out_valid !== m_elig()) begin errors++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", c, out_valid, m_elig()); end
            checks++;
            if (in_ready !== m_ready(a)) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", c, in_ready, m_ready(a)); end
            checks++;
            if (empty !== (mq.size() == 0)) begin errors++; $display("FAIL rnd_empty cyc=%0d got=%b exp=%b", c, empty, mq.size() == 0); end
            checks++;
            if (chk_hit !== m_chk(chk_addr)) begin errors++; $display("FAIL rnd_chk_hit cyc=%0d got=%b exp=%b", c, chk_hit, m_chk(chk_addr)); end
            if (m_elig()) begin
                eb = mq[0].be;
                ed = mq[0].data;
                for (int k = 0; k < 16; k++) m[k*8 +: 8] = {8{eb[k]}};
                checks++;
                if (out_addr !== {mq[0].line, 4'h0}) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, out_addr, {mq[0].line, 4'h0}); end
                checks++;
                if (out_be !== eb) begin errors++; $display("FAIL rnd_be cyc=%0d got=%h exp=%h", c, out_be, eb); end
                checks++;
                if ((out_data & m) !== (ed & m)) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, out_data & m, ed & m); end
            end
            m_step(v, a, d, b, ordy, fl);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        flush = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_merge();
        test_full_line();
        test_full_buffer();
        test_flush();
        test_reset_mid_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
